// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file write-back port arbiter.
package regfile_arb_pkg;

    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned DEFAULT_AW = 5;
    localparam int unsigned DEFAULT_DW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DUMP = 2'd1,
        LAST = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: one-hot grant to the first valid
// requester at or after ptr, searching upward modulo NREQ.
module rr_arbiter #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned PW   = 2
) (
    input  logic [NREQ-1:0] valid,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant
);

    logic w_found;

    // Scan offsets from ptr in priority order; only constant indices are used
    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            for (int unsigned j = 0; j < NREQ; j++) begin
                if (!w_found && valid[j] &&
                    ((32'(ptr) + off == j) || (32'(ptr) + off == j + NREQ))) begin
                    grant[j] = 1'b1;
                    w_found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Arbitrates NREQ write-back requesters onto a single register-file write
// port and streams all registers out on request through a debug read port.
module regfile_port_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    parameter int unsigned AW   = DEFAULT_AW,
    parameter int unsigned DW   = DEFAULT_DW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              RegWrite,
    output logic [AW-1:0]     wads,
    output logic [DW-1:0]     wdata,
    input  logic              dump_start,
    output logic [AW-1:0]     outaddr,
    input  logic [DW-1:0]     reg_data,
    output logic              dump_busy,
    output logic              dump_valid,
    output logic [AW-1:0]     dump_addr,
    output logic [DW-1:0]     dump_data
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          r_state;
    logic [PW-1:0]   r_rr_ptr;
    logic [AW-1:0]   r_cnt;
    logic            r_reg_write;
    logic [AW-1:0]   r_wads;
    logic [DW-1:0]   r_wdata;
    logic            r_dump_busy;
    logic            r_dump_valid;
    logic [AW-1:0]   r_dump_addr;
    logic [DW-1:0]   r_dump_data;

    logic            w_arb_en;
    logic [NREQ-1:0] w_grant;
    logic            w_xfer;
    logic [PW-1:0]   w_win;
    logic [PW-1:0]   w_next_ptr;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_data;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr (
        .valid (req_valid),
        .ptr   (r_rr_ptr),
        .grant (w_grant)
    );

    // Grants only in IDLE and only when no dump is being requested
    assign w_arb_en  = (r_state == IDLE) && !dump_start;
    assign req_ready = w_arb_en ? w_grant : '0;
    assign w_xfer    = |req_ready;
    assign outaddr   = (r_state == DUMP) ? r_cnt : '0;

    // Decode the one-hot grant into winner index and its address/data
    always_comb begin
        w_win      = '0;
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                w_win      = PW'(i);
                w_sel_addr = req_addr[i*AW +: AW];
                w_sel_data = req_data[i*DW +: DW];
            end
        end
    end

    assign w_next_ptr = (w_win == PW'(NREQ - 1)) ? '0 : w_win + PW'(1);

    // Control FSM with registered write-port and dump outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_rr_ptr     <= '0;
            r_cnt        <= '0;
            r_reg_write  <= 1'b0;
            r_wads       <= '0;
            r_wdata      <= '0;
            r_dump_busy  <= 1'b0;
            r_dump_valid <= 1'b0;
            r_dump_addr  <= '0;
            r_dump_data  <= '0;
        end else begin
            r_reg_write  <= 1'b0;
            r_dump_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (dump_start) begin
                        r_state     <= DUMP;
                        r_cnt       <= '0;
                        r_dump_busy <= 1'b1;
                    end else if (w_xfer) begin
                        // Writes to register 0 are acknowledged but discarded
                        r_reg_write <= (w_sel_addr != '0);
                        r_wads      <= w_sel_addr;
                        r_wdata     <= w_sel_data;
                        r_rr_ptr    <= w_next_ptr;
                    end
                end
                DUMP: begin
                    r_dump_valid <= 1'b1;
                    r_dump_addr  <= r_cnt;
                    r_dump_data  <= reg_data;
                    r_cnt        <= r_cnt + AW'(1);
                    if (r_cnt == AW'(NUM_REGS - 1)) begin
                        r_state <= LAST;
                    end
                end
                LAST: begin
                    r_state     <= IDLE;
                    r_dump_busy <= 1'b0;
                end
                default: begin
                    r_state     <= IDLE;
                    r_dump_busy <= 1'b0;
                end
            endcase
        end
    end

    assign RegWrite   = r_reg_write;
    assign wads       = r_wads;
    assign wdata      = r_wdata;
    assign dump_busy  = r_dump_busy;
    assign dump_valid = r_dump_valid;
    assign dump_addr  = r_dump_addr;
    assign dump_data  = r_dump_data;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a small register-file model.
module tb_regfile_port_arbiter;

    localparam int unsigned NREQ = 3;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 RegWrite;
    logic [AW-1:0]        wads;
    logic [DW-1:0]        wdata;
    logic                 dump_start;
    logic [AW-1:0]        outaddr;
    logic [DW-1:0]        reg_data;
    logic                 dump_busy;
    logic                 dump_valid;
    logic [AW-1:0]        dump_addr;
    logic [DW-1:0]        dump_data;

    logic [DW-1:0]        mem [32];

    int total = 0;
    int bad   = 0;
    int strobes;
    int busy_cycles;

    logic [2:0] exp_rdy  [5] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    logic [4:0] exp_wads [5] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd1};

    regfile_port_arbiter #(
        .NREQ (NREQ),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .RegWrite   (RegWrite),
        .wads       (wads),
        .wdata      (wdata),
        .dump_start (dump_start),
        .outaddr    (outaddr),
        .reg_data   (reg_data),
        .dump_busy  (dump_busy),
        .dump_valid (dump_valid),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data)
    );

    always #5 clk = ~clk;

    // Register file model: cleared while in reset, written by the arbiter
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else if (RegWrite) begin
            mem[wads] <= wdata;
        end
    end

    assign reg_data = mem[outaddr];

    // Register contents expected at dump time (hand-derived from the writes)
    function automatic logic [31:0] exp_dump(input int a);
        case (a)
            1:       return 32'h0000_000A;
            2:       return 32'h0000_000B;
            3:       return 32'h0000_000C;
            5:       return 32'h0000_1234;
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst        = 1'b0;
        req_valid  = '0;
        req_addr   = '0;
        req_data   = '0;
        dump_start = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_regwrite", 64'(RegWrite), 64'(0));
        chk("rst_wads", 64'(wads), 64'(0));
        chk("rst_wdata", 64'(wdata), 64'(0));
        chk("rst_dump_valid", 64'(dump_valid), 64'(0));
        chk("rst_dump_addr", 64'(dump_addr), 64'(0));
        chk("rst_dump_data", 64'(dump_data), 64'(0));
        chk("rst_dump_busy", 64'(dump_busy), 64'(0));
        chk("rst_outaddr", 64'(outaddr), 64'(0));
        chk("rst_ready", 64'(req_ready), 64'(0));

        // All three requesters valid: round-robin 0,1,2,0,1
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 3'b111;
        req_addr  = {5'd3, 5'd2, 5'd1};
        req_data  = {32'hC, 32'hB, 32'hA};
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_ready", 64'(req_ready), 64'(exp_rdy[k]));
            chk("rr_regwrite", 64'(RegWrite), 64'(k != 0));
            if (k != 0) chk("rr_wads", 64'(wads), 64'(exp_wads[k]));
            @(negedge clk);
        end

        // Only requester 1, to address 0: acknowledged, no write
        req_valid = 3'b010;
        req_addr  = {5'd3, 5'd0, 5'd1};
        req_data  = {32'hC, 32'hFFFF_FFFF, 32'hA};
        #1;
        chk("x0_ready", 64'(req_ready), 64'(3'b010));
        chk("x0_prev_regwrite", 64'(RegWrite), 64'(1));
        chk("x0_prev_wads", 64'(wads), 64'(2));
        @(negedge clk);
        req_valid = 3'b000;
        #1;
        chk("x0_regwrite", 64'(RegWrite), 64'(0));
        chk("x0_idle_ready", 64'(req_ready), 64'(0));

        // Write x5 = 0x1234, then dump_start the next cycle
        @(negedge clk);
        req_valid = 3'b001;
        req_addr  = {5'd3, 5'd0, 5'd5};
        req_data  = {32'hC, 32'hFFFF_FFFF, 32'h1234};
        #1;
        chk("w5_ready", 64'(req_ready), 64'(3'b001));
        @(negedge clk);
        dump_start = 1'b1;
        #1;
        chk("ds_ready", 64'(req_ready), 64'(0));
        chk("ds_regwrite", 64'(RegWrite), 64'(1));
        chk("ds_wads", 64'(wads), 64'(5));
        chk("ds_wdata", 64'(wdata), 64'(32'h1234));
        chk("ds_busy", 64'(dump_busy), 64'(0));
        @(negedge clk);

        // Full dump with requester 0 held valid and a stray dump_start pulse
        strobes     = 0;
        busy_cycles = 0;
        for (int n = 0; n <= 33; n++) begin
            dump_start = (n == 15);
            #1;
            if (dump_busy)  busy_cycles++;
            if (dump_valid) strobes++;
            chk("dump_busy", 64'(dump_busy), 64'(n <= 32));
            chk("dump_valid", 64'(dump_valid), 64'(n >= 1 && n <= 32));
            if (n >= 1 && n <= 32) begin
                chk("dump_addr", 64'(dump_addr), 64'(n - 1));
                chk("dump_data", 64'(dump_data), 64'(exp_dump(n - 1)));
            end
            if (n <= 31) chk("dump_outaddr", 64'(outaddr), 64'(n));
            chk("dump_ready", 64'(req_ready), (n <= 32) ? 64'(0) : 64'(3'b001));
            @(negedge clk);
        end
        chk("dump_strobes", 64'(strobes), 64'(32));
        chk("dump_busy_cycles", 64'(busy_cycles), 64'(33));

        // Second dump aborted by reset at counter 10
        req_valid  = 3'b000;
        dump_start = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
        for (int m = 0; m < 10; m++) begin
            #1;
            chk("abort_outaddr", 64'(outaddr), 64'(m));
            @(negedge clk);
        end
        #1;
        chk("abort_pre_outaddr", 64'(outaddr), 64'(10));
        chk("abort_pre_valid", 64'(dump_valid), 64'(1));
        rst = 1'b0;
        #1;
        chk("abort_valid", 64'(dump_valid), 64'(0));
        chk("abort_busy", 64'(dump_busy), 64'(0));
        chk("abort_outaddr0", 64'(outaddr), 64'(0));
        chk("abort_dump_addr", 64'(dump_addr), 64'(0));
        chk("abort_regwrite", 64'(RegWrite), 64'(0));
        req_valid = 3'b111;
        req_addr  = {5'd3, 5'd2, 5'd1};
        req_data  = {32'hC, 32'hB, 32'hA};
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_rst_ready", 64'(req_ready), 64'(3'b001));
        @(negedge clk);
        #1;
        chk("post_rst_regwrite", 64'(RegWrite), 64'(1));
        chk("post_rst_wads", 64'(wads), 64'(1));
        chk("post_rst_ready2", 64'(req_ready), 64'(3'b010));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
